arm_reg_file_sb: RTL and testbench
==================================

Name: arm_reg_file_sb

Overview:
Parametrised register file with an integrated per-register pending-write scoreboard.
- Issue stage reserves a destination register when an instruction is dispatched.
- Writeback clears the reservation and writes the data.
- Read ports return data plus a busy flag, so the hazard unit can stall without tracking destinations itself.
- Successor to the fixed 16x32 register file; sits between ID (reads, reserves) and WB (writes).

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 4, register index width; register count NUM_REGS = 2**ADDR_W
- PEND_W, 2, width of each per-register pending counter; max outstanding writes per register = 2**PEND_W-1

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- rd_addr_1  in  ADDR_W  read port 1 index
- rd_addr_2  in  ADDR_W  read port 2 index
- rd_data_1  out  DATA_W  read port 1 data, combinational
- rd_data_2  out  DATA_W  read port 2 data, combinational
- rd_busy_1  out  1  read port 1 register has outstanding write(s)
- rd_busy_2  out  1  read port 2 register has outstanding write(s)
- rsv_en  in  1  reserve request (instruction issued with destination)
- rsv_addr  in  ADDR_W  destination being reserved
- rsv_full  out  1  combinational: counter of rsv_addr at max; reservation will be dropped
- wb_en  in  1  writeback enable
- wb_addr  in  ADDR_W  writeback destination
- wb_data  in  DATA_W  writeback data
- flush  in  1  clear all pending counters (pipeline flush)
- wb_err  out  1  sticky: writeback seen to a register with zero pending count
- any_pending  out  1  registered OR of all counters non-zero

Behaviour:
- Reset (async, immediate):
  - all registers 0, all counters 0, wb_err 0, any_pending 0
  - rd_data_* = 0 and rd_busy_* = 0 while rst is high
- Write: on rising edge with wb_en, reg[wb_addr] <= wb_data. Data is written regardless of counter state.
- Counter update per register r, each rising edge:
  - inc = rsv_en & rsv_addr==r & ~rsv_full
  - dec = wb_en & wb_addr==r & cnt[r]!=0
  - inc & dec -> unchanged
  - inc only -> +1
  - dec only -> -1
- Saturation: when cnt[rsv_addr]==max, rsv_full=1 and the reservation is ignored. The counter never wraps. The issue stage must stall while rsv_full=1.
- Underflow: wb_en to a register with cnt==0 leaves the counter at 0 and sets wb_err. wb_err clears only on rst.
- flush: all counters <= 0 on that edge, overriding inc/dec. A wb_en in the same cycle still writes data. A wb_en in that cycle does not set wb_err when it would otherwise underflow.
- Read busy: rd_busy_n = (cnt[rd_addr_n]!=0), from current registered counters (see optional feature).
- Reads are combinational from the array. Both ports may address the same register.
- any_pending: registered, reflects counters after the edge. One-cycle latency from a counter change.
- Latency: reserve -> busy visible next cycle; writeback -> data and cleared busy visible next cycle (without bypass).

Optional Feature:
Macro: ARM_RF_WRITE_BYPASS_EN
- Defined:
  - a read whose address matches wb_addr with wb_en=1 returns wb_data in the same cycle
  - rd_busy for that port = (cnt>=2), i.e. the post-writeback count is non-zero
  - the bypass applies even when flush=1
- Undefined:
  - reads return array contents only
  - busy uses the current count
  - the consumer must wait one cycle after writeback

Test Plan:
1. Reset then read regs 0 and 15 -> rd_data=0, rd_busy=0, wb_err=0, any_pending=0.
2. rsv r3 at cycle 0; wb r3=0xDEADBEEF at cycle 2; read r3 -> rd_busy_1=1 cycles 1-2. Cycle 3: rd_data_1=0xDEADBEEF, rd_busy=0. With bypass: data valid and busy=0 at cycle 2.
3. Reserve r5 four times (PEND_W=2) -> count reaches 3; fourth cycle rsv_full=1 and count stays 3. Three writebacks bring busy to 0 after the third.
4. Same cycle rsv r7 and wb r7 with cnt[r7]=1 -> count stays 1, data written, rd_busy=1 next cycle.
5. wb r9=0x5 with cnt[r9]=0 -> reg written, wb_err=1 and stays 1 through later cycles until rst.
6. Counters r1=2, r2=1; assert flush with wb r1=0x11 -> next cycle all busy=0, any_pending=0, r1=0x11, wb_err unchanged. Assert rst mid-sequence -> all state 0 immediately, without a clock edge.

Source files
------------

// File: rtl/arm_reg_file_sb.sv
// Register file with a per-register pending-write scoreboard (reserve at ID, release at WB).
// Reads are combinational; counter, wb_err and any_pending updates take effect one edge later.
// No backpressure; rsv_full tells the issue stage to stall. Optional macro: ARM_RF_WRITE_BYPASS_EN.
module arm_reg_file_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr_1,
    input  logic [ADDR_W-1:0] rd_addr_2,
    output logic [DATA_W-1:0] rd_data_1,
    output logic [DATA_W-1:0] rd_data_2,
    output logic              rd_busy_1,
    output logic              rd_busy_2,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              rsv_full,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              wb_err,
    output logic              any_pending
);

    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam logic [PEND_W-1:0] CNT_MAX = {PEND_W{1'b1}};

    logic [DATA_W-1:0] regs    [NUM_REGS];
    logic [PEND_W-1:0] cnt     [NUM_REGS];
    logic [PEND_W-1:0] cnt_nxt [NUM_REGS];
    logic              any_nxt;
    logic              wb_under;

    // A full counter blocks further reservations to that register
    always_comb begin
        rsv_full = (cnt[rsv_addr] == CNT_MAX);
    end

    // Writeback to a register nobody reserved; a flush in the same cycle masks it
    always_comb begin
        wb_under = wb_en && (cnt[wb_addr] == '0) && !flush;
    end

    // Next counter values: simultaneous reserve and release cancel, flush clears everything
    always_comb begin
        any_nxt = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            logic inc;
            logic dec;
            inc = rsv_en && (rsv_addr == ADDR_W'(r)) && !rsv_full;
            dec = wb_en && (wb_addr == ADDR_W'(r)) && (cnt[r] != '0);
            cnt_nxt[r] = cnt[r];
            if (flush) begin
                cnt_nxt[r] = '0;
            end else if (inc && !dec) begin
                cnt_nxt[r] = cnt[r] + 1'b1;
            end else if (dec && !inc) begin
                cnt_nxt[r] = cnt[r] - 1'b1;
            end
            if (cnt_nxt[r] != '0) begin
                any_nxt = 1'b1;
            end
        end
    end

    // Register array: writeback data is stored whatever the counter state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
        end else if (wb_en) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Scoreboard state, sticky underflow flag and registered pending summary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
            wb_err      <= 1'b0;
            any_pending <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= cnt_nxt[r];
            end
            if (wb_under) begin
                wb_err <= 1'b1;
            end
            any_pending <= any_nxt;
        end
    end

    // Read ports; outputs are forced to zero while reset is held
`ifdef ARM_RF_WRITE_BYPASS_EN
    // Forward the in-flight writeback; busy reflects the count after this release
    always_comb begin
        rd_data_1 = regs[rd_addr_1];
        rd_busy_1 = (cnt[rd_addr_1] != '0);
        rd_data_2 = regs[rd_addr_2];
        rd_busy_2 = (cnt[rd_addr_2] != '0);
        if (wb_en && (wb_addr == rd_addr_1)) begin
            rd_data_1 = wb_data;
            rd_busy_1 = (cnt[rd_addr_1] > PEND_W'(1));
        end
        if (wb_en && (wb_addr == rd_addr_2)) begin
            rd_data_2 = wb_data;
            rd_busy_2 = (cnt[rd_addr_2] > PEND_W'(1));
        end
        if (rst) begin
            rd_data_1 = '0;
            rd_data_2 = '0;
            rd_busy_1 = 1'b0;
            rd_busy_2 = 1'b0;
        end
    end
`else
    // Plain array reads; consumers wait one cycle after writeback
    always_comb begin
        rd_data_1 = rst ? '0 : regs[rd_addr_1];
        rd_data_2 = rst ? '0 : regs[rd_addr_2];
        rd_busy_1 = !rst && (cnt[rd_addr_1] != '0);
        rd_busy_2 = !rst && (cnt[rd_addr_2] != '0);
    end
`endif

endmodule

// File: tb/tb_arm_reg_file_sb.sv
// Bench for arm_reg_file_sb: directed scenarios followed by random traffic.
// Expected values come from an array-based model of registers and pending counts.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_arm_reg_file_sb;

    localparam int DW  = 32;
    localparam int AW  = 4;
    localparam int NR  = 16;
    localparam int MAX = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] rd_addr_1, rd_addr_2, rsv_addr, wb_addr;
    logic [DW-1:0] rd_data_1, rd_data_2, wb_data;
    logic          rd_busy_1, rd_busy_2, rsv_en, rsv_full, wb_en, flush, wb_err, any_pending;

    int n_chk = 0;
    int n_err = 0;

    // reference model
    logic [DW-1:0] m_reg [NR];
    int            m_cnt [NR];
    logic          m_err;
    logic          m_anyp;

    always #5 clk = ~clk;

    arm_reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .PEND_W(2)) dut (
        .clk(clk), .rst(rst),
        .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
        .rd_data_1(rd_data_1), .rd_data_2(rd_data_2),
        .rd_busy_1(rd_busy_1), .rd_busy_2(rd_busy_2),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_full(rsv_full),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush), .wb_err(wb_err), .any_pending(any_pending)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NR; r++) begin
            m_reg[r] = '0;
            m_cnt[r] = 0;
        end
        m_err  = 1'b0;
        m_anyp = 1'b0;
    endtask

    // expected read result for one port given the current model and writeback
    task automatic exp_read(input int a, input logic we, input int wa, input logic [DW-1:0] wd,
                            output logic [DW-1:0] d, output logic b);
        d = m_reg[a];
        b = (m_cnt[a] > 0);
`ifdef ARM_RF_WRITE_BYPASS_EN
        if (we && wa == a) begin
            d = wd;
            b = (m_cnt[a] - 1 > 0);
        end
`endif
    endtask

    // one clock cycle: drive, check combinational/registered outputs, advance model
    task automatic step(input logic re, input int ra, input logic we, input int wa,
                        input logic [DW-1:0] wd, input logic fl, input int a1, input int a2);
        logic [DW-1:0] d;
        logic          b;
        int            new_cnt [NR];
        @(negedge clk);
        rsv_en = re; rsv_addr = AW'(ra);
        wb_en = we; wb_addr = AW'(wa); wb_data = wd;
        flush = fl; rd_addr_1 = AW'(a1); rd_addr_2 = AW'(a2);
        #1;
        exp_read(a1, we, wa, wd, d, b);
        chk("rd_data_1", 64'(rd_data_1), 64'(d));
        chk("rd_busy_1", 64'(rd_busy_1), 64'(b));
        exp_read(a2, we, wa, wd, d, b);
        chk("rd_data_2", 64'(rd_data_2), 64'(d));
        chk("rd_busy_2", 64'(rd_busy_2), 64'(b));
        chk("rsv_full", 64'(rsv_full), 64'(m_cnt[ra] == MAX));
        chk("wb_err", 64'(wb_err), 64'(m_err));
        chk("any_pending", 64'(any_pending), 64'(m_anyp));
        @(posedge clk);
        // counts after the edge: saturating reservation, release only if pending
        for (int r = 0; r < NR; r++) begin
            new_cnt[r] = m_cnt[r];
            if (re && ra == r && m_cnt[r] < MAX) new_cnt[r] = new_cnt[r] + 1;
            if (we && wa == r && m_cnt[r] > 0)   new_cnt[r] = new_cnt[r] - 1;
            if (fl) new_cnt[r] = 0;
        end
        if (we && m_cnt[wa] == 0 && !fl) m_err = 1'b1;
        if (we) m_reg[wa] = wd;
        m_anyp = 1'b0;
        for (int r = 0; r < NR; r++) begin
            m_cnt[r] = new_cnt[r];
            if (new_cnt[r] > 0) m_anyp = 1'b1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rd_data_1"}, 64'(rd_data_1), 64'd0);
        chk({tag, "_rd_data_2"}, 64'(rd_data_2), 64'd0);
        chk({tag, "_rd_busy_1"}, 64'(rd_busy_1), 64'd0);
        chk({tag, "_rd_busy_2"}, 64'(rd_busy_2), 64'd0);
        chk({tag, "_wb_err"}, 64'(wb_err), 64'd0);
        chk({tag, "_any_pending"}, 64'(any_pending), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        rsv_en = 0; rsv_addr = '0; wb_en = 0; wb_addr = '0; wb_data = '0; flush = 0;
        rd_addr_1 = 4'd0; rd_addr_2 = 4'd15;
        model_reset();
        // 1: reset state
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 0, 0, 0, 0, 0, 15);

        // 2: reserve r3, writeback two cycles later
        step(1, 3, 0, 0, 0, 0, 3, 3);
        step(0, 0, 0, 0, 0, 0, 3, 3);
        step(0, 0, 1, 3, 32'hDEADBEEF, 0, 3, 3);
        step(0, 0, 0, 0, 0, 0, 3, 3);

        // 3: saturate r5 then drain it
        for (int i = 0; i < 4; i++) step(1, 5, 0, 0, 0, 0, 5, 3);
        chk("r5_full", 64'(rsv_full), 64'd1);
        for (int i = 0; i < 3; i++) step(0, 5, 1, 5, 32'(i + 1), 0, 5, 5);
        step(0, 5, 0, 0, 0, 0, 5, 5);

        // 4: simultaneous reserve and writeback on r7 with one pending
        step(1, 7, 0, 0, 0, 0, 7, 7);
        step(1, 7, 1, 7, 32'h77, 0, 7, 7);
        step(0, 0, 0, 0, 0, 0, 7, 7);
        step(0, 0, 1, 7, 32'h78, 0, 7, 7);

        // 5: underflow on r9 sets sticky error
        step(0, 0, 1, 9, 32'h5, 0, 9, 9);
        step(0, 0, 0, 0, 0, 0, 9, 9);
        step(0, 0, 0, 0, 0, 0, 9, 9);

        // 6: flush with concurrent writeback, then async reset mid-sequence
        step(1, 1, 0, 0, 0, 0, 1, 2);
        step(1, 1, 0, 0, 0, 0, 1, 2);
        step(1, 2, 0, 0, 0, 0, 1, 2);
        step(0, 0, 1, 1, 32'h11, 1, 1, 2);
        step(0, 0, 0, 0, 0, 0, 1, 2);
        step(1, 4, 0, 0, 0, 0, 1, 4);
        step(0, 0, 0, 0, 0, 0, 1, 4);
        @(negedge clk);
        rsv_en = 0; wb_en = 0; flush = 0;
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // random traffic over a small address window to exercise collisions
        for (int i = 0; i < 3000; i++) begin
            logic [DW-1:0] wd;
            wd = $urandom;
            step(($urandom_range(0, 99) < 45), $urandom_range(0, 5),
                 ($urandom_range(0, 99) < 40), $urandom_range(0, 5), wd,
                 ($urandom_range(0, 99) < 3),
                 $urandom_range(0, 5), $urandom_range(0, 15));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
